// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-state data memory controller.
package dmem_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_LANES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Expand a per-byte lane mask into a per-bit mask.
  function automatic logic [WORD_W-1:0] lane_bits(input logic [BYTE_LANES-1:0] mask);
    logic [WORD_W-1:0] bits;
    bits = '0;
    for (int l = 0; l < BYTE_LANES; l++) begin
      bits[8*l +: 8] = {8{mask[l]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/dmem_wait_ctrl_if.sv
// Request/response bus between a requester and the data memory controller.
interface dmem_wait_ctrl_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32
);
  logic                  dm_req;
  logic                  dm_wr_req;
  logic [ADDR_W-1:0]     dm_addr;
  logic [WORD_W-1:0]     dm_data_in;
  logic [BYTE_LANES-1:0] dm_wr_mask;
  logic                  dm_ready;
  logic                  dm_valid;
  logic [WORD_W-1:0]     dm_data_o;
  logic                  dm_err;

  modport master (
    output dm_req, dm_wr_req, dm_addr, dm_data_in, dm_wr_mask,
    input  dm_ready, dm_valid, dm_data_o, dm_err
  );

  modport slave (
    input  dm_req, dm_wr_req, dm_addr, dm_data_in, dm_wr_mask,
    output dm_ready, dm_valid, dm_data_o, dm_err
  );
endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 storage with per-lane write enables and a registered read port.
// Storage has no reset so contents survive a controller reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BYTE_LANES-1:0] we,
  input  logic                  re,
  input  logic [IDX_W-1:0]      addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_d, rdata_q;
  logic [WORD_W-1:0] wbits_s;

  // Lane-merge write: unmasked bytes keep their old contents.
  always_ff @(posedge clk) begin
    if (we != 4'b0000) begin
      mem_q[addr] <= (mem_q[addr] & ~wbits_s) | (wdata & wbits_s);
    end
  end

  // Read data mux: capture the addressed word only on a read, otherwise zero.
  always_comb begin
    wbits_s = lane_bits(we);
    rdata_d = '0;
    if (re) begin
      rdata_d = mem_q[addr];
    end else begin
      rdata_d = '0;
    end
  end

  // Read data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_wait_ctrl.sv
// Data memory front end: accepts one request, inserts WAIT_CYCLES wait
// states, then returns a one-cycle response with read data or an error.
module dmem_wait_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  dmem_wait_ctrl_if.slave  bus
);

  localparam int                IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH);
  localparam logic [3:0]        CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic                  err_q, err_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [WORD_W-1:0]     data_q, data_d;
  logic [BYTE_LANES-1:0] mask_q, mask_d;

  logic                  accept_s, enter_resp_s, err_in_s;
  logic [ADDR_W-1:0]     word_idx_s;
  logic                  acc_wr_s, acc_err_s;
  logic [IDX_W-1:0]      acc_idx_s;
  logic [WORD_W-1:0]     acc_data_s;
  logic [BYTE_LANES-1:0] acc_mask_s;
  logic [BYTE_LANES-1:0] we_s;
  logic                  re_s;
  logic [WORD_W-1:0]     rdata_s;

  // State and wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: IDLE -> (WAIT ->) RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = RESP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state; response fields only in RESP.
  always_comb begin
    bus.dm_ready  = 1'b0;
    bus.dm_valid  = 1'b0;
    bus.dm_err    = 1'b0;
    bus.dm_data_o = '0;
    case (state_q)
      IDLE: bus.dm_ready = 1'b1;
      WAIT: bus.dm_ready = 1'b0;
      RESP: begin
        bus.dm_valid  = 1'b1;
        bus.dm_err    = err_q;
        bus.dm_data_o = (wr_q || err_q) ? '0 : rdata_s;
      end
      default: bus.dm_ready = 1'b0;
    endcase
  end

  // Request decode and operand selection. With zero wait states the memory
  // access happens at the accept edge itself, so the live bus operands are
  // used in IDLE and the captured copies otherwise.
  always_comb begin
    accept_s     = (state_q == IDLE) && bus.dm_req;
    enter_resp_s = (state_d == RESP) && (state_q != RESP);
    word_idx_s   = {2'b00, bus.dm_addr[ADDR_W-1:2]};
    err_in_s     = (bus.dm_addr[1:0] != 2'b00) || (word_idx_s >= DEPTH_L);
    if (state_q == IDLE) begin
      acc_wr_s   = bus.dm_wr_req;
      acc_err_s  = err_in_s;
      acc_idx_s  = bus.dm_addr[IDX_W+1:2];
      acc_data_s = bus.dm_data_in;
      acc_mask_s = bus.dm_wr_mask;
    end else begin
      acc_wr_s   = wr_q;
      acc_err_s  = err_q;
      acc_idx_s  = idx_q;
      acc_data_s = data_q;
      acc_mask_s = mask_q;
    end
    we_s = (enter_resp_s && acc_wr_s && !acc_err_s && !rst) ? acc_mask_s : 4'b0000;
    re_s = enter_resp_s && !acc_wr_s && !acc_err_s;
  end

  // Capture the request operands at the accept edge, hold them otherwise.
  always_comb begin
    wr_d   = wr_q;
    err_d  = err_q;
    idx_d  = idx_q;
    data_d = data_q;
    mask_d = mask_q;
    if (accept_s) begin
      wr_d   = bus.dm_wr_req;
      err_d  = err_in_s;
      idx_d  = bus.dm_addr[IDX_W+1:2];
      data_d = bus.dm_data_in;
      mask_d = bus.dm_wr_mask;
    end else begin
      wr_d   = wr_q;
    end
  end

  // Captured request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= 1'b0;
      err_q  <= 1'b0;
      idx_q  <= '0;
      data_q <= '0;
      mask_q <= 4'b0000;
    end else begin
      wr_q   <= wr_d;
      err_q  <= err_d;
      idx_q  <= idx_d;
      data_q <= data_d;
      mask_q <= mask_d;
    end
  end

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (we_s),
    .re    (re_s),
    .addr  (acc_idx_s),
    .wdata (acc_data_s),
    .rdata (rdata_s)
  );

endmodule
